input_frame_ctrl: RTL
=====================

// Module: input_frame_ctrl
// PURPOSE
//  Sequences loading of one 784-pixel binary image from the UART receive path into the
//  single-port input RAM, then hands the RAM port to snn_core and pulses start.
//  Owns the RAM address/we mux (loader vs. core) and guards the RAM against UART traffic
//  while a classification is running. Aborts stalled frames after a timeout.
//  Sits between uart_rx and ram_input_unit/snn_core in the snn top level.
// PARAMETERS
//  FRAME_BITS   784        pixels per image (bits written to RAM); multiple of 8
//  ADDR_W       10         RAM address width
//  TIMEOUT_CYC  1_000_000  idle cycles allowed between bytes of one frame (20 ms @ 50 MHz)
// PORTS
//  clk          in   1       system clock, 50 MHz
//  rst_n        in   1       asynchronous active-low reset
//  rx_rdy       in   1       one-cycle pulse: rx_data valid
//  rx_data      in   8       received byte, pixel 0 of the byte in bit 0
//  core_addr    in   ADDR_W  RAM read address from snn_core
//  done         in   1       one-cycle pulse from snn_core: digit ready
//  ram_addr     out  ADDR_W  RAM address
//  ram_wdata    out  1       RAM write data (one pixel)
//  ram_we       out  1       RAM write enable
//  start        out  1       one-cycle pulse to snn_core
//  frame_busy   out  1       high whenever state != IDLE
//  overrun      out  1       sticky: a byte was dropped
//  timeout_err  out  1       one-cycle pulse: partial frame aborted
// BEHAVIOUR
//  Reset: state=IDLE, bit_cnt=0, all outputs 0, ram_addr=0, byte/pending registers cleared.
//  States: IDLE, SHIFT, WAIT_BYTE, START, RUN.
//  IDLE: rx_rdy -> latch byte into shift reg, clear overrun, go to SHIFT.
//  SHIFT: 8 consecutive cycles; each cycle ram_we=1, ram_addr=bit_cnt, ram_wdata=shift[0];
//    shift >>1, bit_cnt+1. After the 8th write: bit_cnt==FRAME_BITS -> START;
//    else pending byte held -> SHIFT again (no gap cycle); else -> WAIT_BYTE.
//  Latency: rx_rdy at cycle 0 -> writes in cycles 1..8, LSB first.
//  WAIT_BYTE: timeout counter increments each cycle; rx_rdy -> latch byte, clear counter,
//    go to SHIFT. Counter reaching TIMEOUT_CYC-1 without rx_rdy -> timeout_err pulse,
//    bit_cnt=0, go to IDLE. rx_rdy in the terminal-count cycle wins (no timeout).
//  rx_rdy during SHIFT: stored in one-byte pending register; a second byte while pending
//    is full is dropped and sets overrun.
//  START: ram_addr=core_addr, ram_we=0, start=1 for exactly this cycle -> RUN.
//  RUN: ram_addr=core_addr, ram_we=0; done -> bit_cnt=0, go to IDLE.
//  rx_rdy in START/RUN: byte dropped, overrun set. done outside RUN: ignored.
//  ram_wdata=0 and ram_we=0 in all states except SHIFT.
//  bit_cnt is ADDR_W bits; never wraps (max value FRAME_BITS=784 < 1024).
//  Timeout counter width $clog2(TIMEOUT_CYC); saturates at the terminal count only for one cycle.
//  Reset mid-frame or mid-RUN returns to IDLE immediately; partial RAM contents are left
//    as is and are overwritten by the next frame.
// STRUCTURE
//  snn_pkg: FRAME_BITS, ADDR_W constants; frame_state_t enum {IDLE,SHIFT,WAIT_BYTE,START,RUN}.
//  One sub-module: byte_serializer (8-bit load/shift reg + 3-bit count + last flag);
//    FSM, pending register, timeout counter and address mux stay in this module.
// TESTING
//  98 bytes 0xA5, 1 per 1000 cycles -> 784 writes, addr 0..783, data 1,0,1,0,0,1,0,1
//    repeating; single start pulse 1 cycle after write to addr 783.
//  After start, drive core_addr=0x123 -> ram_addr==0x123, ram_we==0 until done;
//    done -> frame_busy falls next cycle.
//  rx_rdy during RUN -> overrun=1, no RAM write; next frame's first byte clears it.
//  10 bytes then silence, TIMEOUT_CYC=100 -> timeout_err pulse 100 cycles after last
//    write; next byte writes from addr 0.
//  Two rx_rdy 2 cycles apart -> 16 back-to-back writes, addr 0..15, overrun=0;
//    third rx_rdy before first byte finishes -> overrun=1.
//  Assert rst_n low mid-SHIFT -> all outputs 0 asynchronously; new frame loads from addr 0.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN image input path.
package snn_pkg;

  localparam int FRAME_BITS  = 784;
  localparam int ADDR_W      = 10;
  localparam int TIMEOUT_CYC = 1_000_000;
  localparam int BYTE_W      = 8;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT_BYTE,
    START,
    RUN
  } frame_state_t;

endpackage

// File: rtl/byte_serializer.sv
// Loads one received byte and presents it LSB first, one bit per shift.
// 'last' flags the eighth bit of the byte currently being shifted.
module byte_serializer
  import snn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              shift_en,
  output logic              bit_out,
  output logic              last
);

  localparam int CNT_W = $clog2(BYTE_W);

  logic [BYTE_W-1:0] shift_reg;
  logic [CNT_W-1:0]  cnt_reg;

  // Load wins over shift so a new byte can follow the last bit with no gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else if (load) begin
      shift_reg <= load_data;
      cnt_reg   <= '0;
    end else if (shift_en) begin
      shift_reg <= {1'b0, shift_reg[BYTE_W-1:1]};
      cnt_reg   <= cnt_reg + CNT_W'(1);
    end
  end

  assign bit_out = shift_reg[0];
  assign last    = (cnt_reg == {CNT_W{1'b1}});

endmodule

// File: rtl/input_frame_ctrl.sv
// Loads one binary image from the UART byte stream into the single-port input
// RAM, then hands the RAM port to snn_core and pulses start. Bytes arriving
// while a classification runs are dropped and flagged; stalled frames time out.
module input_frame_ctrl #(
  parameter int FRAME_BITS  = 784,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wdata,
  output logic              ram_we,
  output logic              start,
  output logic              frame_busy,
  output logic              overrun,
  output logic              timeout_err
);

  import snn_pkg::*;

  localparam int TCNT_W = $clog2(TIMEOUT_CYC);

  frame_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0]        pend_data_reg, pend_data_next;
  logic              pend_vld_reg, pend_vld_next;
  logic              overrun_reg, overrun_next;
  logic [TCNT_W-1:0] tcnt_reg, tcnt_next;

  logic              ser_load;
  logic [7:0]        ser_data;
  logic              ser_shift;
  logic              ser_bit;
  logic              ser_last;

  byte_serializer u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ser_load),
    .load_data (ser_data),
    .shift_en  (ser_shift),
    .bit_out   (ser_bit),
    .last      (ser_last)
  );

  // State, pixel counter, one-byte pending slot, sticky overrun and idle timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      pend_data_reg <= '0;
      pend_vld_reg  <= 1'b0;
      overrun_reg   <= 1'b0;
      tcnt_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      pend_data_reg <= pend_data_next;
      pend_vld_reg  <= pend_vld_next;
      overrun_reg   <= overrun_next;
      tcnt_reg      <= tcnt_next;
    end
  end

  // Next-state logic plus the RAM port mux: loader owns it until START.
  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    pend_data_next = pend_data_reg;
    pend_vld_next  = pend_vld_reg;
    overrun_next   = overrun_reg;
    tcnt_next      = '0;
    ser_load       = 1'b0;
    ser_data       = rx_data;
    ser_shift      = 1'b0;
    ram_addr       = bit_cnt_reg;
    ram_wdata      = 1'b0;
    ram_we         = 1'b0;
    start          = 1'b0;
    timeout_err    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rx_rdy) begin
          ser_load     = 1'b1;
          overrun_next = 1'b0;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        ram_we       = 1'b1;
        ram_wdata    = ser_bit;
        ser_shift    = 1'b1;
        bit_cnt_next = bit_cnt_reg + ADDR_W'(1);
        if (ser_last) begin
          if (bit_cnt_reg == ADDR_W'(FRAME_BITS - 1)) begin
            // Frame complete: anything queued belongs to no frame.
            state_next    = START;
            pend_vld_next = 1'b0;
            if (pend_vld_reg || rx_rdy) begin
              overrun_next = 1'b1;
            end
          end else if (pend_vld_reg) begin
            // Pending byte follows immediately; a byte arriving now refills the slot.
            ser_load       = 1'b1;
            ser_data       = pend_data_reg;
            pend_vld_next  = rx_rdy;
            pend_data_next = rx_data;
          end else if (rx_rdy) begin
            ser_load = 1'b1;
          end else begin
            state_next = WAIT_BYTE;
          end
        end else if (rx_rdy) begin
          if (pend_vld_reg) begin
            overrun_next = 1'b1;
          end else begin
            pend_vld_next  = 1'b1;
            pend_data_next = rx_data;
          end
        end
      end
      WAIT_BYTE: begin
        if (rx_rdy) begin
          ser_load   = 1'b1;
          state_next = SHIFT;
        end else if (tcnt_reg == TCNT_W'(TIMEOUT_CYC - 1)) begin
          timeout_err  = 1'b1;
          bit_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          tcnt_next = tcnt_reg + TCNT_W'(1);
        end
      end
      START: begin
        ram_addr   = core_addr;
        start      = 1'b1;
        state_next = RUN;
        if (rx_rdy) begin
          overrun_next = 1'b1;
        end
      end
      RUN: begin
        ram_addr = core_addr;
        if (rx_rdy) begin
          overrun_next = 1'b1;
        end
        if (done) begin
          bit_cnt_next = '0;
          state_next   = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign overrun    = overrun_reg;
  assign frame_busy = (state_reg != IDLE);

endmodule
